mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
Downstream consumer of the 4x4 array multiplier's 8-bit product bus. Accepts COUNT successive products over a valid/ready handshake and sums them into a dot-product result. Presents the result on a second valid/ready handshake. Turns the purely combinational multiplier into a sequential 4-element dot-product engine.

Parameters:
COUNT, 4, number of products summed per result (>=1)
ACC_W, 10, accumulator/result width; default holds 4*225=900 without overflow

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse; begins a new accumulation (honoured in IDLE only)
in_prod  input  8  unsigned product from multiplier (p[7:0])
in_valid  input  1  in_prod valid this cycle
in_ready  output  1  block accepts in_prod this cycle
out_acc  output  ACC_W  accumulated result
out_sat  output  1  result saturated (sum exceeded 2^ACC_W-1)
out_valid  output  1  out_acc/out_sat valid
out_ready  input  1  downstream takes result
busy  output  1  high in ACCUM or DONE

Behaviour:
Decided: one clock (clk); reset rst is synchronous, active-high.
- Reset (rst=1 at edge): state=IDLE, acc=0, cnt=0, out_acc=0, out_sat=0, out_valid=0, in_ready=0, busy=0. rst overrides all other inputs in the same cycle.
- States: IDLE, ACCUM, DONE. All outputs registered or decoded from state only; no combinational path from in_valid/out_ready to any output.
- IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM next cycle; acc<=0, cnt<=0, sat<=0.
- ACCUM: in_ready=1. Accept = in_valid & in_ready. On accept: acc<=acc+in_prod (zero-extended); cnt<=cnt+1. in_valid=0 -> hold, no change.
- Saturation: if acc+in_prod > 2^ACC_W-1 -> acc<=all-ones, sat<=1; sat is sticky until next start.
- Accept with cnt==COUNT-1 -> DONE next cycle; out_acc<=final sum, out_sat<=sat.
- Latency: out_valid rises 1 cycle after the edge accepting the COUNT-th product.
- DONE: in_ready=0, out_valid=1, out_acc/out_sat stable. out_valid & out_ready -> IDLE next cycle; out_valid drops. out_acc keeps last value in IDLE until next DONE.
- start outside IDLE: ignored (no restart, no state change).
- start and in_valid in same IDLE cycle: in_prod not accepted (in_ready=0 in IDLE).
- COUNT=1: a single accept goes ACCUM->DONE.
- cnt width: clog2(COUNT)+1; no wrap inside one accumulation.
- Reset mid-ACCUM or mid-DONE: partial sum discarded, returns to IDLE with reset values.
- busy = (state!=IDLE).

Test Plan:
- Reset: rst high 2 cycles, any inputs -> out_valid=0, in_ready=0, busy=0, out_acc=0, out_sat=0.
- Basic dot product: start, then products 6,12,20,30 back-to-back (in_valid held), out_ready=1 -> out_acc=68, out_sat=0, out_valid exactly 1 cycle after 4th accept, then IDLE.
- Max values and stalls: products 225,225,225,225 with in_valid low 2 cycles between each -> out_acc=900, out_sat=0; gaps add nothing.
- Backpressure: result ready, out_ready low 5 cycles -> out_valid and out_acc held stable; start pulses during DONE ignored; out_ready high -> IDLE next cycle.
- Saturation (ACC_W=8): products 200,100,0,0 -> out_acc=255, out_sat=1; next run 1,2,3,4 -> out_acc=10, out_sat=0.
- Reset mid-op: start, accept 50,60, assert rst one cycle, then start with 1,1,1,1 -> out_acc=4; no residue from 110.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums COUNT successive 8-bit products taken over a
// valid/ready handshake into one dot-product result, then presents that
// result on a second valid/ready handshake. Saturating, sticky overflow flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result of the previous run still on out_acc
// ACCUM | taking products (in_ready=1) until COUNT have been accepted
// DONE  | result valid (out_valid=1), held until downstream takes it
module mac_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(COUNT) + 1;
    // Wide enough to hold acc + a full 8-bit product even when ACC_W < 8.
    localparam int SUM_W = ((ACC_W > 8) ? ACC_W : 8) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
    localparam logic [SUM_W-1:0] ACC_MAX  = SUM_W'({ACC_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;

    logic               accept;
    logic [SUM_W-1:0]   sum_full;
    logic               ovf;
    logic [ACC_W-1:0]   acc_next;
    logic               sat_next;

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Next accumulator value with clamp-to-all-ones on overflow.
    always_comb begin
        accept   = in_valid && (state == ACCUM);
        sum_full = SUM_W'(acc) + SUM_W'(in_prod);
        ovf      = (sum_full > ACC_MAX);
        acc_next = ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
        sat_next = sat | ovf;
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            out_acc <= '0;
            out_sat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        sat <= sat_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state   <= DONE;
                            out_acc <= acc_next;
                            out_sat <= sat_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (ACC_W=10 and ACC_W=8) share the
// same stimulus; each is checked against a sum-and-clamp reference.
module tb_mac_accumulator;

    typedef logic [3:0][7:0] prod_t;

    typedef struct {
        prod_t p;
        int    gap;
        int    hold;
        bit    stray;
        int    e10;
        int    s10;
        int    e8;
        int    s8;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_prod;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_w, out_sat_w, out_valid_w, busy_w;
    logic [9:0] out_acc_w;
    logic       in_ready_n, out_sat_n, out_valid_n, busy_n;
    logic [7:0] out_acc_n;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mac_accumulator #(.COUNT(4), .ACC_W(10)) u_wide (
        .clk(clk), .rst(rst), .start(start), .in_prod(in_prod),
        .in_valid(in_valid), .in_ready(in_ready_w), .out_acc(out_acc_w),
        .out_sat(out_sat_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .busy(busy_w)
    );

    mac_accumulator #(.COUNT(4), .ACC_W(8)) u_narrow (
        .clk(clk), .rst(rst), .start(start), .in_prod(in_prod),
        .in_valid(in_valid), .in_ready(in_ready_n), .out_acc(out_acc_n),
        .out_sat(out_sat_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .busy(busy_n)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready_w"},  int'(in_ready_w),  0);
        check({tag, "_out_valid_w"}, int'(out_valid_w), 0);
        check({tag, "_busy_w"},      int'(busy_w),      0);
        check({tag, "_in_ready_n"},  int'(in_ready_n),  0);
        check({tag, "_out_valid_n"}, int'(out_valid_n), 0);
        check({tag, "_busy_n"},      int'(busy_n),      0);
    endtask

    // Reference: sum everything, then clamp; the flag says whether it clamped.
    function automatic int model_acc(input prod_t p, input int w);
        int total = 0;
        int mx = (1 << w) - 1;
        for (int i = 0; i < 4; i++) total += int'(p[i]);
        return (total > mx) ? mx : total;
    endfunction

    function automatic int model_sat(input prod_t p, input int w);
        int total = 0;
        int mx = (1 << w) - 1;
        for (int i = 0; i < 4; i++) total += int'(p[i]);
        return (total > mx) ? 1 : 0;
    endfunction

    task automatic add_vec(input int a, input int b, input int c, input int d,
                           input int gap, input int hold, input bit stray,
                           input int e10, input int s10, input int e8, input int s8);
        vec_t v;
        v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c); v.p[3] = 8'(d);
        v.gap = gap; v.hold = hold; v.stray = stray;
        v.e10 = e10; v.s10 = s10; v.e8 = e8; v.s8 = s8;
        vecs.push_back(v);
    endtask

    // One full run from IDLE back to IDLE, checking latency and result.
    task automatic run_txn(input prod_t p, input int gap, input int hold, input bit stray,
                           input int e10, input int s10, input int e8, input int s8);
        start = 1'b1;
        if (stray) begin
            in_valid = 1'b1;
            in_prod  = 8'd99;
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("accum_in_ready_w", int'(in_ready_w), 1);
        check("accum_busy_n",     int'(busy_n),     1);
        for (int i = 0; i < 4; i++) begin
            in_prod  = p[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i < 3) begin
                check("early_valid_w", int'(out_valid_w), 0);
                in_prod = 8'hFF;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_in_ready_w", int'(in_ready_w), 1);
                end
            end
        end
        check("done_valid_w",    int'(out_valid_w), 1);
        check("done_valid_n",    int'(out_valid_n), 1);
        check("done_in_ready_w", int'(in_ready_w),  0);
        check("acc_w", int'(out_acc_w), e10);
        check("sat_w", int'(out_sat_w), s10);
        check("acc_n", int'(out_acc_n), e8);
        check("sat_n", int'(out_sat_n), s8);
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            tick();
            start = 1'b0;
            check("hold_valid_w", int'(out_valid_w), 1);
            check("hold_acc_w",   int'(out_acc_w),   e10);
            check("hold_acc_n",   int'(out_acc_n),   e8);
            check("hold_busy_n",  int'(busy_n),      1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle("after_take");
        check("idle_keep_acc_w", int'(out_acc_w), e10);
        check("idle_keep_acc_n", int'(out_acc_n), e8);
    endtask

    initial begin
        prod_t rp;
        int    rgap, rhold;

        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_prod = 8'd200; out_ready = 1'b1;
        tick();
        check_idle("rst1");
        tick();
        check_idle("rst2");
        check("rst_acc_w", int'(out_acc_w), 0);
        check("rst_sat_w", int'(out_sat_w), 0);
        check("rst_acc_n", int'(out_acc_n), 0);
        check("rst_sat_n", int'(out_sat_n), 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check_idle("post_rst");

        //       products           gap hold stray  wide     narrow
        add_vec(6, 12, 20, 30,       0, 0, 1'b0,  68, 0,   68, 0);
        add_vec(225, 225, 225, 225,  2, 0, 1'b0, 900, 0,  255, 1);
        add_vec(200, 100, 0, 0,      0, 0, 1'b0, 300, 0,  255, 1);
        add_vec(1, 2, 3, 4,          0, 0, 1'b0,  10, 0,   10, 0);
        add_vec(9, 8, 7, 6,          1, 5, 1'b0,  30, 0,   30, 0);
        add_vec(1, 1, 1, 1,          0, 0, 1'b1,   4, 0,    4, 0);
        add_vec(255, 255, 255, 255,  1, 1, 1'b0, 1020, 0, 255, 1);
        add_vec(0, 0, 0, 0,          0, 0, 1'b0,   0, 0,    0, 0);

        foreach (vecs[k]) begin
            run_txn(vecs[k].p, vecs[k].gap, vecs[k].hold, vecs[k].stray,
                    vecs[k].e10, vecs[k].s10, vecs[k].e8, vecs[k].s8);
        end

        // Reset in the middle of an accumulation discards the partial sum.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_prod = 8'd50; in_valid = 1'b1;
        tick();
        in_prod = 8'd60;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_acc_w", int'(out_acc_w), 0);
        check("mid_rst_sat_n", int'(out_sat_n), 0);
        rp = '0;
        for (int i = 0; i < 4; i++) rp[i] = 8'd1;
        run_txn(rp, 0, 0, 1'b0, 4, 0, 4, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 4; i++) rp[i] = 8'($urandom_range(0, 255));
            rgap  = int'($urandom_range(0, 2));
            rhold = int'($urandom_range(0, 2));
            run_txn(rp, rgap, rhold, 1'($urandom_range(0, 1)),
                    model_acc(rp, 10), model_sat(rp, 10),
                    model_acc(rp, 8),  model_sat(rp, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
